// File: rtl/mul_arb.sv
// mul_arb: two-requester arbiter feeding a fixed-latency (3) multiplier, with credit
// flow control into a first-word-fall-through result FIFO. Define MUL_ARB_RR_EN for round-robin arbitration.
module mul_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  input  logic [1:0]              req_sa,
  input  logic [1:0]              req_sb,
  input  logic [2*REG_WIDTH-1:0]  req_r1,
  input  logic [2*REG_WIDTH-1:0]  req_r2,
  output logic [DATA_WIDTH-1:0]   mul_in1,
  output logic [DATA_WIDTH-1:0]   mul_in2,
  output logic                    mul_s1,
  output logic                    mul_s2,
  output logic [REG_WIDTH-1:0]    mul_r1,
  output logic [REG_WIDTH-1:0]    mul_r2,
  input  logic [DATA_WIDTH-1:0]   mul_outl,
  input  logic [DATA_WIDTH-1:0]   mul_outh,
  input  logic [REG_WIDTH-1:0]    mul_r1o,
  input  logic [REG_WIDTH-1:0]    mul_r2o,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_lo,
  output logic [DATA_WIDTH-1:0]   res_hi,
  output logic [REG_WIDTH-1:0]    res_r1,
  output logic [REG_WIDTH-1:0]    res_r2,
  output logic                    res_id
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] hi;
    logic [REG_WIDTH-1:0]  r1;
    logic [REG_WIDTH-1:0]  r2;
    logic                  id;
  } res_t;

  logic [2:0]       stg_vld;
  logic [2:0]       stg_id;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] credits;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             permitted;
  logic             issue;
  logic             gnt_id;
  logic             push;
  logic             pop;
  res_t             mem [FIFO_DEPTH];
  res_t             head;

  // Every slot ever granted (in flight or queued) is reserved, so a push never finds the FIFO full.
  // NOTE: every variable in an always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < 3; k++) inflight = inflight + CNT_W'(stg_vld[k]);
    credits   = CNT_W'(FIFO_DEPTH) - fifo_count - inflight;
    permitted = rst_n && (credits != '0);
    issue     = permitted && (req_valid != 2'b00);
  end

`ifdef MUL_ARB_RR_EN
  logic rr_ptr;

  // The preferred requester wins when valid; otherwise the other one takes the slot.
  always_comb begin
    gnt_id = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_ptr <= 1'b0;
    else if (issue) rr_ptr <= ~gnt_id;
  end
`else
  always_comb begin
    gnt_id = ~req_valid[0];
  end
`endif

  assign req_ready = {issue & gnt_id, issue & ~gnt_id};

  always_comb begin
    mul_in1 = '0;
    mul_in2 = '0;
    mul_s1  = 1'b0;
    mul_s2  = 1'b0;
    mul_r1  = '0;
    mul_r2  = '0;
    if (issue) begin
      mul_in1 = gnt_id ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
      mul_in2 = gnt_id ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
      mul_s1  = req_sa[gnt_id];
      mul_s2  = req_sb[gnt_id];
      mul_r1  = gnt_id ? req_r1[2*REG_WIDTH-1:REG_WIDTH] : req_r1[REG_WIDTH-1:0];
      mul_r2  = gnt_id ? req_r2[2*REG_WIDTH-1:REG_WIDTH] : req_r2[REG_WIDTH-1:0];
    end
  end

  // Shadow of the multiplier pipeline: stage 3 lines up with valid data on mul_out*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      stg_id  <= '0;
    end else begin
      stg_vld <= {stg_vld[1:0], issue};
      stg_id  <= {stg_id[1:0], gnt_id};
    end
  end

  assign push = stg_vld[2];
  assign pop  = res_valid && res_ready;

  // NOTE: the storage array is not reset; outputs are masked by res_valid, so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{lo: mul_outl, hi: mul_outh, r1: mul_r1o, r2: mul_r2o, id: stg_id[2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign res_valid = (fifo_count != '0);
  assign head      = res_valid ? mem[rd_ptr] : '0;
  assign res_lo    = head.lo;
  assign res_hi    = head.hi;
  assign res_r1    = head.r1;
  assign res_r2    = head.r2;
  assign res_id    = head.id;

endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: drives mul_arb with directed and random traffic, models the 3-deep multiplier,
// and checks every cycle against a queue-based model of issues, landing times and pops.
module tb_mul_arb;
  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_a = '0, req_b = '0;
  logic [1:0]      req_sa = '0, req_sb = '0;
  logic [2*RW-1:0] req_r1 = '0, req_r2 = '0;
  logic [DW-1:0]   mul_in1, mul_in2, mul_outl, mul_outh;
  logic            mul_s1, mul_s2;
  logic [RW-1:0]   mul_r1, mul_r2, mul_r1o, mul_r2o;
  logic            res_valid, res_ready = 1'b0;
  logic [DW-1:0]   res_lo, res_hi;
  logic [RW-1:0]   res_r1, res_r2;
  logic            res_id;

  mul_arb #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sa(req_sa), .req_sb(req_sb),
    .req_r1(req_r1), .req_r2(req_r2),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_s1(mul_s1), .mul_s2(mul_s2),
    .mul_r1(mul_r1), .mul_r2(mul_r2),
    .mul_outl(mul_outl), .mul_outh(mul_outh), .mul_r1o(mul_r1o), .mul_r2o(mul_r2o),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_lo(res_lo), .res_hi(res_hi), .res_r1(res_r1), .res_r2(res_r2), .res_id(res_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*DW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic sa, input logic sb);
    logic [2*DW-1:0] ax, bx;
    ax = sa ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    bx = sb ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    return ax * bx;
  endfunction

  // Multiplier: three register stages, cleared by the shared reset.
  logic [2*DW-1:0] mp [3];
  logic [RW-1:0]   m1 [3];
  logic [RW-1:0]   m2 [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mp[k] <= '0;
        m1[k] <= '0;
        m2[k] <= '0;
      end
    end else begin
      mp[0] <= prod(mul_in1, mul_in2, mul_s1, mul_s2);
      m1[0] <= mul_r1;
      m2[0] <= mul_r2;
      for (int k = 1; k < 3; k++) begin
        mp[k] <= mp[k-1];
        m1[k] <= m1[k-1];
        m2[k] <= m2[k-1];
      end
    end
  end
  assign mul_outl = mp[2][DW-1:0];
  assign mul_outh = mp[2][2*DW-1:DW];
  assign mul_r1o  = m1[2];
  assign mul_r2o  = m2[2];

  // Reference model: an issue at edge E is visible at the FIFO head after edge E+3,
  // and occupies one slot from issue until it is popped.
  typedef struct {
    logic [2*DW-1:0] p;
    logic [RW-1:0]   r1;
    logic [RW-1:0]   r2;
    logic            id;
    int              land;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  logic pref = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : cmp
    logic [1:0]   exp_rdy;
    logic         gid;
    logic         exp_vld;
    logic [127:0] exp_mul;
    exp_t         e;
    if (!rst_n) begin
      exp_q.delete();
      pref = 1'b0;
      check("reset_outputs", {req_ready, res_valid, res_lo, res_hi, res_r1, res_r2, res_id}, '0);
      check("reset_mul", {mul_in1, mul_in2, mul_s1, mul_s2, mul_r1, mul_r2}, '0);
    end else begin
      exp_rdy = 2'b00;
      gid     = 1'b0;
      exp_mul = '0;
      if (exp_q.size() < DEPTH && req_valid != 2'b00) begin
        gid = req_valid[pref] ? pref : !pref;
        exp_rdy[gid] = 1'b1;
        exp_mul = {req_a[gid*DW +: DW], req_b[gid*DW +: DW], req_sa[gid], req_sb[gid],
                   req_r1[gid*RW +: RW], req_r2[gid*RW +: RW]};
      end
      check("grant", req_ready, exp_rdy);
      check("mul_drive", {mul_in1, mul_in2, mul_s1, mul_s2, mul_r1, mul_r2}, exp_mul);

      exp_vld = (exp_q.size() > 0) && (exp_q[0].land <= cyc);
      check("res_valid", res_valid, exp_vld);
      if (exp_vld && res_valid) begin
        e = exp_q[0];
        check("result", {res_hi, res_lo, res_r1, res_r2, res_id}, {e.p, e.r1, e.r2, e.id});
        if (res_ready) void'(exp_q.pop_front());
      end

      if (exp_rdy != 2'b00) begin
        e.p    = prod(req_a[gid*DW +: DW], req_b[gid*DW +: DW], req_sa[gid], req_sb[gid]);
        e.r1   = req_r1[gid*RW +: RW];
        e.r2   = req_r2[gid*RW +: RW];
        e.id   = gid;
        e.land = cyc + 4;
        exp_q.push_back(e);
`ifdef MUL_ARB_RR_EN
        pref = !gid;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic sa, input logic sb, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_sa[i]          = sa;
    req_sb[i]          = sb;
    req_r1[i*RW +: RW] = r1;
    req_r2[i*RW +: RW] = r2;
  endtask

  task automatic set_rand(input int i);
    set_req(i, DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            RW'($urandom), RW'($urandom));
  endtask

  task automatic drain();
    bit done = 0;
    req_valid = 2'b00;
    res_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid) begin
        done = 1;
        break;
      end
    end
    check("drain_done", done, 1);
    tick();
  endtask

  // Issue one op from requester i, then wait for its result at the FIFO head.
  task automatic single_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic sa, input logic sb, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                           input logic [DW-1:0] exp_lo, input logic [DW-1:0] exp_hi, input string tag);
    bit got = 0;
    set_req(i, a, b, sa, sb, r1, r2);
    res_ready = 1'b1;
    req_valid = 2'b00;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1;
        break;
      end
    end
    check({tag, "_issued"}, got, 1);
    tick();
    req_valid = 2'b00;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1;
        break;
      end
    end
    check({tag, "_arrived"}, got, 1);
    check({tag, "_value"}, {res_hi, res_lo, res_r1, res_r2, res_id},
          {exp_hi, exp_lo, r1, r2, 1'(i)});
    tick();
  endtask

  initial begin : stim
    int       ng, nh;
    bit       flag;
    logic [3:0] gseq;

    repeat (3) @(negedge clk);
    tick();
    rst_n = 1'b1;

    // Contention straight out of reset: pointer starts at requester 0.
    set_rand(0);
    set_rand(1);
    res_ready = 1'b1;
    req_valid = 2'b11;
    ng   = 0;
    gseq = '0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        gseq[ng] = req_ready[1];
        ng++;
      end
      tick();
    end
    req_valid = 2'b00;
    check("contention_count", ng, 4);
`ifdef MUL_ARB_RR_EN
    check("contention_order", gseq, 4'b1010);
`else
    check("contention_order", gseq, 4'b0000);
`endif
    drain();

    single_op(0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 5'd7, 5'd9, 32'hFFFF_FFF1, 32'hFFFF_FFFF, "signed_op");
    single_op(1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 5'd3, 5'd4, 32'hFFFF_FFFE, 32'h0000_0001, "unsigned_op");
    drain();

    // Result consumer stalled: exactly DEPTH issues fit, then issue stops until pops free slots.
    res_ready = 1'b0;
    set_rand(0);
    set_rand(1);
    req_valid = 2'b11;
    nh = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) nh++;
      tick();
    end
    check("full_issue_count", nh, DEPTH);
    @(negedge clk);
    check("full_stalled", req_ready, 2'b00);
    tick();
    res_ready = 1'b1;
    flag = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        flag = 1;
        break;
      end
      tick();
    end
    check("issue_resumes", flag, 1);
    tick();
    drain();

    // Reset with one result queued and two still in the multiplier.
    res_ready = 1'b0;
    set_rand(0);
    req_valid = 2'b01;
    nh = 0;
    for (int c = 0; c < 10 && nh < 3; c++) begin
      @(negedge clk);
      if (req_ready[0]) nh++;
      tick();
    end
    req_valid = 2'b00;
    flag = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_valid) begin
        flag = 1;
        break;
      end
    end
    check("pre_reset_result", flag, 1);
    #2;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    check("reset_res_valid", res_valid, 1'b0);
    check("reset_req_ready", req_ready, 2'b00);
    repeat (2) @(negedge clk);
    tick();
    rst_n     = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b1;
    repeat (10) tick();

    // Random traffic with bursts of back-pressure.
    for (int c = 0; c < 800; c++) begin
      set_rand(0);
      set_rand(1);
      req_valid = 2'($urandom_range(0, 3));
      if ((c % 100) < 30) res_ready = ($urandom_range(0, 3) == 0);
      else                res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
